cell_bist_ctrl: RTL and testbench

Built-in self-test sequencer for a single 3-input combinational standard cell (e.g. NOR3X1, NAND3X1, AOI21X1) in the OSU cell library test harness. It drives the cell's A/B/C inputs through all eight input vectors and waits a programmable settle time per vector. It samples the cell's Y output, compares each sample against a programmable 8-entry truth table, and reports pass/fail, the first failing vector and the mismatch count. It sits between the harness's test register file and one cell-under-test (CUT) instance.

---
 rtl/cell_bist_ctrl_if.sv | 27 ++
 rtl/cell_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_cell_bist_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_bist_ctrl_if.sv
// Bundles the register-file and cell-under-test signals of the cell BIST sequencer.
// The master side is the harness/CUT; the slave side is the sequencer itself.
interface cell_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] truth_table;
    logic       y_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_vec;
    logic [3:0] fail_count;
    logic [7:0] y_capture;

    modport master (
        output start, abort, truth_table, y_in,
        input  a, b, c, busy, done, pass, fail_vec, fail_count, y_capture
    );

    modport slave (
        input  start, abort, truth_table, y_in,
        output a, b, c, busy, done, pass, fail_vec, fail_count, y_capture
    );
endinterface

// File: rtl/cell_bist_ctrl.sv
// Exhaustive 8-vector BIST sequencer for one 3-input combinational cell:
// steps {a,b,c} through 0..7, samples Y after a settle time, checks against a truth table.
module cell_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cell_bist_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    // With no settle time each vector goes straight to its sample cycle.
    localparam state_t RUN_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tt_q, tt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic [3:0] fail_count_q, fail_count_d;
    logic [7:0] ycap_q, ycap_d;
    logic       mismatch;

    assign mismatch = (bus.y_in != tt_q[vec_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            tt_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= '0;
            fail_count_q <= '0;
            ycap_q       <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            tt_q         <= tt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_vec_q   <= fail_vec_d;
            fail_count_q <= fail_count_d;
            ycap_q       <= ycap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        tt_d         = tt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_vec_d   = fail_vec_q;
        fail_count_d = fail_count_q;
        ycap_d       = ycap_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    tt_d         = bus.truth_table;
                    pass_d       = 1'b0;
                    fail_vec_d   = '0;
                    fail_count_d = '0;
                    ycap_d       = '0;
                    vec_d        = '0;
                    cnt_d        = SETTLE_LOAD;
                    busy_d       = 1'b1;
                    state_d      = RUN_ENTRY;
                end
            end

            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (cnt_q <= 8'd1) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    ycap_d[vec_q] = bus.y_in;
                    if (mismatch) begin
                        fail_count_d = fail_count_q + 4'd1;
                        if (fail_count_q == 4'd0) begin
                            fail_vec_d = vec_q;
                        end
                    end
                    if (vec_q != 3'd7) begin
                        vec_d   = vec_q + 3'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = RUN_ENTRY;
                    end else begin
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == 4'd0);
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a          = vec_q[2];
    assign bus.b          = vec_q[1];
    assign bus.c          = vec_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_vec   = fail_vec_q;
    assign bus.fail_count = fail_count_q;
    assign bus.y_capture  = ycap_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Directed bench for cell_bist_ctrl: NOR3/NAND3/stuck-at CUT models on a 2-cycle
// settle instance and a zero-settle instance, with hand-computed expectations.
module tb_cell_bist_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   mode;

    cell_bist_ctrl_if bus2 ();
    cell_bist_ctrl_if bus0 ();

    cell_bist_ctrl #(.SETTLE_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    cell_bist_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    // mode 0 = ideal NOR3, 1 = stuck-at-0, 2 = ideal NAND3
    function automatic logic cut_y(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return ~(a | b | c);
            1:       return 1'b0;
            default: return ~(a & b & c);
        endcase
    endfunction

    assign bus2.y_in = cut_y(mode, bus2.a, bus2.b, bus2.c);
    assign bus0.y_in = cut_y(mode, bus0.a, bus0.b, bus0.c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves any DONE cycle, pulses start for one cycle; returns just after E0.
    task automatic pulse_start(input bit use0, input logic [7:0] tt);
        tick();
        if (use0) begin
            bus0.truth_table = tt;
            bus0.start = 1'b1;
        end else begin
            bus2.truth_table = tt;
            bus2.start = 1'b1;
        end
        tick();
        bus0.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    // Counts edges until done is seen; -1 if it never comes within the budget.
    task automatic wait_done(input bit use0, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if ((use0 ? bus0.done : bus2.done) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [21:0] outs;
        rst_n = 1'b0;
        tick();
        tick();
        outs = {bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.c,
                bus2.fail_vec, bus2.fail_count, bus2.y_capture};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", outs);
        end
        #2 rst_n = 1'b1;
        // Mid-run reset while vector 5 is applied
        mode = 0;
        pulse_start(1'b0, 8'h01);
        for (int k = 1; k <= 16; k++) tick();
        vectors++;
        if ({bus2.a, bus2.b, bus2.c} !== 3'd5) begin
            miscompares++;
            $display("FAIL reset_pre_vec: got %0d expected 5", {bus2.a, bus2.b, bus2.c});
        end
        rst_n = 1'b0;
        #1;
        outs = {bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.c,
                bus2.fail_vec, bus2.fail_count, bus2.y_capture};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_async_midrun: got %h expected 0", outs);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_nor3();
        logic [4:0] got;
        logic [4:0] exp;
        mode = 0;
        pulse_start(1'b0, 8'h01);
        vectors++;
        if ({bus2.busy, bus2.a, bus2.b, bus2.c} !== 4'b1000) begin
            miscompares++;
            $display("FAIL nor3_e0: got %b expected 1000", {bus2.busy, bus2.a, bus2.b, bus2.c});
        end
        for (int k = 1; k < 24; k++) begin
            tick();
            got = {bus2.busy, bus2.done, bus2.a, bus2.b, bus2.c};
            exp = {1'b1, 1'b0, 3'(k / 3)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL nor3_step k=%0d: got %b expected %b", k, got, exp);
            end
        end
        tick();
        vectors++;
        if ({bus2.done, bus2.busy, bus2.pass, bus2.a, bus2.b, bus2.c} !== 6'b101000) begin
            miscompares++;
            $display("FAIL nor3_done_flags: got %b expected 101000",
                     {bus2.done, bus2.busy, bus2.pass, bus2.a, bus2.b, bus2.c});
        end
        vectors++;
        if ({bus2.fail_count, bus2.fail_vec, bus2.y_capture} !== {4'd0, 3'd0, 8'h01}) begin
            miscompares++;
            $display("FAIL nor3_results: got cnt=%0d vec=%0d y=%h expected cnt=0 vec=0 y=01",
                     bus2.fail_count, bus2.fail_vec, bus2.y_capture);
        end
        tick();
        vectors++;
        if ({bus2.done, bus2.pass} !== 2'b01) begin
            miscompares++;
            $display("FAIL nor3_after_done: got done=%b pass=%b expected done=0 pass=1",
                     bus2.done, bus2.pass);
        end
    endtask

    task automatic test_stuck0();
        int cyc;
        mode = 1;
        pulse_start(1'b0, 8'h01);
        wait_done(1'b0, cyc);
        vectors++;
        if (cyc !== 24) begin
            miscompares++;
            $display("FAIL stuck0_latency: got %0d expected 24", cyc);
        end
        vectors++;
        if ({bus2.pass, bus2.fail_vec, bus2.fail_count, bus2.y_capture} !== {1'b0, 3'd0, 4'd1, 8'h00}) begin
            miscompares++;
            $display("FAIL stuck0_results: got pass=%b vec=%0d cnt=%0d y=%h expected pass=0 vec=0 cnt=1 y=00",
                     bus2.pass, bus2.fail_vec, bus2.fail_count, bus2.y_capture);
        end
    endtask

    task automatic test_nand3();
        int cyc;
        mode = 2;
        pulse_start(1'b0, 8'h01);
        wait_done(1'b0, cyc);
        vectors++;
        if (cyc !== 24) begin
            miscompares++;
            $display("FAIL nand3_latency: got %0d expected 24", cyc);
        end
        vectors++;
        if ({bus2.pass, bus2.fail_vec, bus2.fail_count, bus2.y_capture} !== {1'b0, 3'd1, 4'd6, 8'h7F}) begin
            miscompares++;
            $display("FAIL nand3_results: got pass=%b vec=%0d cnt=%0d y=%h expected pass=0 vec=1 cnt=6 y=7f",
                     bus2.pass, bus2.fail_vec, bus2.fail_count, bus2.y_capture);
        end
    endtask

    task automatic test_busy_start_and_abort();
        int  done_at;
        int  cyc;
        bit  seen_done;
        mode = 0;
        pulse_start(1'b0, 8'h01);
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            bus2.start = (k == 5 || k == 10);
            if (bus2.done === 1'b1 && done_at < 0) done_at = k;
        end
        bus2.start = 1'b0;
        vectors++;
        if (done_at !== 24) begin
            miscompares++;
            $display("FAIL busy_start_ignored: done at %0d expected 24", done_at);
        end
        // Abort while vector 3 is applied
        pulse_start(1'b0, 8'h01);
        for (int k = 1; k <= 10; k++) tick();
        vectors++;
        if ({bus2.a, bus2.b, bus2.c} !== 3'd3) begin
            miscompares++;
            $display("FAIL abort_pre_vec: got %0d expected 3", {bus2.a, bus2.b, bus2.c});
        end
        bus2.abort = 1'b1;
        tick();
        vectors++;
        if ({bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.c} !== 6'b000000) begin
            miscompares++;
            $display("FAIL abort_idle: got %b expected 000000",
                     {bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.c});
        end
        vectors++;
        if ({bus2.y_capture, bus2.fail_count} !== {8'h01, 4'd0}) begin
            miscompares++;
            $display("FAIL abort_partial: got y=%h cnt=%0d expected y=01 cnt=0",
                     bus2.y_capture, bus2.fail_count);
        end
        bus2.abort = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus2.done === 1'b1 || bus2.busy === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got activity=%b expected 0", seen_done);
        end
        pulse_start(1'b0, 8'h01);
        wait_done(1'b0, cyc);
        vectors++;
        if (cyc !== 24 || bus2.pass !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_rerun: got cyc=%0d pass=%b expected cyc=24 pass=1", cyc, bus2.pass);
        end
    endtask

    task automatic test_settle0();
        int cyc;
        mode = 0;
        pulse_start(1'b1, 8'h01);
        for (int k = 1; k < 8; k++) begin
            tick();
            vectors++;
            if ({bus0.busy, bus0.a, bus0.b, bus0.c} !== {1'b1, 3'(k)}) begin
                miscompares++;
                $display("FAIL settle0_step k=%0d: got %b expected %b", k,
                         {bus0.busy, bus0.a, bus0.b, bus0.c}, {1'b1, 3'(k)});
            end
        end
        tick();
        cyc = (bus0.done === 1'b1) ? 8 : -1;
        vectors++;
        if (cyc !== 8 || bus0.pass !== 1'b1 || bus0.y_capture !== 8'h01) begin
            miscompares++;
            $display("FAIL settle0_done: got done=%b pass=%b y=%h expected done=1 pass=1 y=01",
                     bus0.done, bus0.pass, bus0.y_capture);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode = 0;
        tick();
        bus2.truth_table = 8'h01;
        bus2.start = 1'b1;
        tick();
        wait_done(1'b0, cyc);
        vectors++;
        if (cyc !== 24) begin
            miscompares++;
            $display("FAIL b2b_first: got %0d expected 24", cyc);
        end
        tick();
        vectors++;
        if ({bus2.busy, bus2.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_gap: got busy=%b done=%b expected 00", bus2.busy, bus2.done);
        end
        tick();
        bus2.start = 1'b0;
        vectors++;
        if ({bus2.busy, bus2.pass, bus2.y_capture} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL b2b_restart: got busy=%b pass=%b y=%h expected busy=1 pass=0 y=00",
                     bus2.busy, bus2.pass, bus2.y_capture);
        end
        wait_done(1'b0, cyc);
        vectors++;
        if (cyc !== 24 || bus2.pass !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got cyc=%0d pass=%b expected cyc=24 pass=1", cyc, bus2.pass);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        rst_n       = 1'b0;
        bus2.start = 1'b0;  bus2.abort = 1'b0;  bus2.truth_table = 8'h00;
        bus0.start = 1'b0;  bus0.abort = 1'b0;  bus0.truth_table = 8'h00;

        test_reset();
        test_nor3();
        test_stuck0();
        test_nand3();
        test_busy_start_and_abort();
        test_settle0();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
